// File: rtl/axi_write_scheduler.sv
// rtl/axi_write_scheduler.sv - shared AXI4 AW/W path scheduler for NrPorts requesters
// Round-robin AW grant, in-order burst tracking queue, W steering with regenerated WLAST.
module axi_write_scheduler #(
  parameter int unsigned NrPorts        = 3,
  parameter int unsigned MaxOutstanding = 4,
  parameter int unsigned LenWidth       = 8,
  localparam int unsigned SelWidth      = $clog2(NrPorts),
  localparam int unsigned PtrWidth      = $clog2(MaxOutstanding),
  localparam int unsigned CntWidth      = PtrWidth + 1
) (
  input  logic                         clk_i,
  input  logic                         rst_ni,
  input  logic [NrPorts-1:0]           aw_valid_i,
  input  logic [NrPorts*LenWidth-1:0]  aw_len_i,
  output logic [NrPorts-1:0]           aw_ready_o,
  output logic                         aw_valid_o,
  input  logic                         aw_ready_i,
  output logic [SelWidth-1:0]          aw_sel_o,
  input  logic [NrPorts-1:0]           w_valid_i,
  input  logic [NrPorts-1:0]           w_last_i,
  output logic [NrPorts-1:0]           w_ready_o,
  output logic                         w_valid_o,
  input  logic                         w_ready_i,
  output logic                         w_last_o,
  output logic [SelWidth-1:0]          w_sel_o,
  output logic [CntWidth-1:0]          outstanding_o,
  output logic                         len_err_o
);

  logic [SelWidth-1:0] rr_q;
  logic                lock_q;
  logic [SelWidth-1:0] lock_sel_q;
  logic [SelWidth-1:0] arb_sel;
  logic [SelWidth-1:0] grant_sel;
  logic [SelWidth-1:0] idx_sel;
  logic                found;
  int                  idx;

  logic [SelWidth-1:0] q_port [MaxOutstanding];
  logic [LenWidth-1:0] q_len  [MaxOutstanding];
  logic [PtrWidth-1:0] head_q;
  logic [PtrWidth-1:0] tail_q;
  logic [CntWidth-1:0] count_q;
  logic [LenWidth-1:0] beat_q;
  logic                err_q;

  logic                any_valid;
  logic                full;
  logic                nonempty;
  logic                push;
  logic                pop;
  logic                w_hs;
  logic [SelWidth-1:0] head_sel;
  logic [LenWidth-1:0] head_len;

  // First requesting port at or after the round-robin pointer.
  always_comb begin
    arb_sel = '0;
    found   = 1'b0;
    idx     = 0;
    idx_sel = '0;
    for (int i = 0; i < int'(NrPorts); i++) begin
      idx = int'(rr_q) + i;
      if (idx >= int'(NrPorts)) idx = idx - int'(NrPorts);
      idx_sel = SelWidth'(idx);
      if (!found && aw_valid_i[idx_sel]) begin
        found   = 1'b1;
        arb_sel = idx_sel;
      end
    end
  end

  // A pending, unaccepted AW keeps its grant so the payload mux stays put.
  assign grant_sel = lock_q ? lock_sel_q : arb_sel;
  assign any_valid = |aw_valid_i;
  assign full      = (count_q == CntWidth'(MaxOutstanding));

  assign aw_valid_o = rst_ni & any_valid & ~full;
  assign aw_ready_o = (aw_valid_o & aw_ready_i) ? (NrPorts'(1) << grant_sel) : '0;
  assign aw_sel_o   = rst_ni ? grant_sel : '0;
  assign push       = aw_valid_o & aw_ready_i;

  assign nonempty  = (count_q != '0);
  assign head_sel  = q_port[head_q];
  assign head_len  = q_len[head_q];

  assign w_sel_o   = nonempty ? head_sel : '0;
  assign w_valid_o = nonempty & w_valid_i[head_sel];
  assign w_ready_o = (nonempty & w_ready_i) ? (NrPorts'(1) << head_sel) : '0;
  assign w_last_o  = nonempty & (beat_q == head_len);
  assign w_hs      = w_valid_o & w_ready_i;
  assign pop       = w_hs & w_last_o;

  assign outstanding_o = count_q;
  assign len_err_o     = err_q;

  always_ff @(posedge clk_i) begin
    if (push) begin
      q_port[tail_q] <= grant_sel;
      q_len[tail_q]  <= aw_len_i[grant_sel*LenWidth +: LenWidth];
    end
  end

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      rr_q       <= '0;
      lock_q     <= 1'b0;
      lock_sel_q <= '0;
      head_q     <= '0;
      tail_q     <= '0;
      count_q    <= '0;
      beat_q     <= '0;
      err_q      <= 1'b0;
    end else begin
      lock_q     <= aw_valid_o & ~aw_ready_i;
      lock_sel_q <= grant_sel;
      if (push) begin
        rr_q   <= (grant_sel == SelWidth'(NrPorts - 1)) ? '0 : grant_sel + 1'b1;
        tail_q <= tail_q + 1'b1;
      end
      if (pop) head_q <= head_q + 1'b1;
      if (push && !pop) count_q <= count_q + 1'b1;
      else if (pop && !push) count_q <= count_q - 1'b1;
      if (w_hs) beat_q <= w_last_o ? '0 : beat_q + 1'b1;
      // The burst length is trusted from AW; a disagreeing requester WLAST is only reported.
      if (w_hs && (w_last_i[head_sel] != w_last_o)) err_q <= 1'b1;
    end
  end

endmodule
